// File: rtl/mips_defs.sv
// mips_defs: shared state encodings and constants for the sequential multiplier
package mips_defs;
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_CALC = 2'd1,
    MS_DONE = 2'd2
  } ms_state_t;
  localparam int MULT_ITER = 32;
endpackage

// File: rtl/_32bit_add.sv
// _32bit_add: 32-bit ripple-carry adder
module _32bit_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  // carry ripples bit by bit from cin upward
  always_comb begin
    logic c;
    c = cin;
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: 32x32 unsigned shift-and-add multiplier sharing one ripple adder
module mult_seq_ctrl
  import mips_defs::*;
#(
  parameter int N_ITER = MULT_ITER,
  parameter int CNT_W  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product_hi,
  output logic [31:0] product_lo
);
  ms_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0] mcand_reg, hi_reg, lo_reg, sum;
  logic cout, last;
  assign last = cnt == CNT_W'(N_ITER - 1);
  _32bit_add u_add (
    .a    (hi_reg),
    .b    (lo_reg[0] ? mcand_reg : 32'h0),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );
  // state register
  always_ff @(posedge clk)
    state <= reset ? MS_IDLE : state_nxt;
  // next state and handshake outputs; start is only honoured in idle
  always_comb begin
    state_nxt = state;
    busy = state != MS_IDLE;
    done = state == MS_DONE;
    case (state)
      MS_IDLE: state_nxt = start ? MS_CALC : MS_IDLE;
      MS_CALC: state_nxt = last ? MS_DONE : MS_CALC;
      default: state_nxt = MS_IDLE;
    endcase
  end
  // operand capture, 65-bit shift of {cout,sum,lo} per iteration, and counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      mcand_reg <= '0;
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (state == MS_IDLE && start) begin
      cnt <= '0;
      mcand_reg <= multiplicand;
      hi_reg <= '0;
      lo_reg <= multiplier;
    end else if (state == MS_CALC) begin
      cnt <= last ? cnt : cnt + 1'b1;
      {hi_reg, lo_reg} <= {cout, sum, lo_reg[31:1]};
    end
  end
  assign product_hi = hi_reg;
  assign product_lo = lo_reg;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed self-checking bench for mult_seq_ctrl
module tb_mult_seq_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] multiplicand = '0, multiplier = '0;
  logic busy, done;
  logic [31:0] product_hi, product_lo;
  int n_chk = 0, n_fail = 0;

  mult_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input int pulse_at);
    logic early_done, lost_busy;
    early_done = 1'b0;
    lost_busy = 1'b0;
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    @(posedge clk); #1;
    chk("busy_after_accept", busy, 1'b1);
    start = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk); #1;
      early_done |= done;
      lost_busy |= ~busy;
      start = (i == pulse_at);
      multiplicand = start ? 32'd7 : 32'hdead_beef;
      multiplier = start ? 32'd9 : 32'h1234_5678;
    end
    start = 1'b0;
    chk("no_early_done", early_done, 1'b0);
    chk("busy_in_calc", lost_busy, 1'b0);
    @(posedge clk); #1;
    chk("done_at_e32", done, 1'b1);
    chk("busy_in_done", busy, 1'b1);
    chk("product", {product_hi, product_lo}, exp);
    @(posedge clk); #1;
    chk("done_one_cycle", {busy, done}, 2'b00);
    chk("product_held", {product_hi, product_lo}, exp);
  endtask

  initial begin
    logic saw_done;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, product_hi, product_lo}, 66'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy, done, product_hi, product_lo}, 66'd0);
    mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", {busy, product_hi, product_lo}, {1'b0, 64'hF});
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
    mul(32'h1234_5678, 32'd0, 64'd0, -1);
    mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, -1);
    mul(32'd6, 32'd7, 64'd42, 10);
    mul(32'd7, 32'd9, 64'd63, -1);
    start = 1'b1;
    multiplicand = 32'd6;
    multiplier = 32'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_abort", {busy, done, product_hi, product_lo}, 66'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      saw_done |= done | busy;
    end
    chk("no_done_after_abort", saw_done, 1'b0);
    mul(32'd2, 32'd2, 64'd4, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Multi-cycle unsigned 32x32 multiplier controller for the MIPS datapath. It implements multu by shift-and-add, time-sharing one instance of the existing 32-bit ripple adder _32bit_add over 32 iterations. The result is 64 bits, presented as HI and LO for the HI/LO register pair. A start/busy/done handshake lets the datapath control unit stall while the multiply runs.

Parameters:
- N_ITER, 32, number of add/shift iterations. Fixed at 32 to match the 32-bit adder width; any other value is unsupported.
- CNT_W, 6, width of the iteration counter. Must hold N_ITER.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request to begin a multiply; accepted only in IDLE.
- multiplicand, input, 32, operand A (rs); sampled on the accepting edge.
- multiplier, input, 32, operand B (rt); sampled on the accepting edge.
- busy, output, 1, high from the accepting edge until the edge that leaves DONE.
- done, output, 1, one-cycle pulse; product is valid while it is high.
- product_hi, output, 32, upper 32 bits of the product.
- product_lo, output, 32, lower 32 bits of the product.

Behaviour:
- Reset (synchronous, checked on every edge, overrides everything):
  - state = IDLE; counter = 0.
  - hi_reg, lo_reg and mcand_reg = 0.
  - Outputs: busy = 0, done = 0, product_hi = 0, product_lo = 0.
  - Reset mid-operation aborts the multiply; no done pulse follows.
- Datapath:
  - Registers: mcand_reg[31:0], hi_reg[31:0], lo_reg[31:0].
  - Adder connections: a = hi_reg, b = (lo_reg[0] ? mcand_reg : 32'h0), cin = 0.
  - Adder outputs: sum[31:0] and cout.
- States:
  - IDLE: busy = 0, done = 0.
    - If start = 1: mcand_reg <= multiplicand, lo_reg <= multiplier, hi_reg <= 0, counter <= 0, go to CALC.
    - If start = 0: stay in IDLE and hold hi_reg/lo_reg, so the previous product stays visible.
  - CALC: busy = 1.
    - Each edge: {hi_reg, lo_reg} <= {cout, sum, lo_reg[31:1]}, i.e. a 65-bit value right-shifted by one; counter <= counter + 1.
    - When counter == N_ITER-1 on an edge, go to DONE.
  - DONE: busy = 1, done = 1 for exactly one cycle; go to IDLE unconditionally.
- Latency is fixed:
  - Accepting edge E0; CALC edges E1..E32; done is high in the cycle after E32.
  - The next start can be accepted at E34 at the earliest: E33 leaves DONE, so IDLE is the cycle after E33.
  - No early termination for zero or small operands.
- product_hi and product_lo are driven directly from hi_reg and lo_reg:
  - They are valid and stable from done until the next accepted start.
  - Intermediate values during CALC are visible but undefined for consumers.
- start while busy (CALC or DONE) is ignored; no queueing. The operand inputs may change freely after E0.
- Arithmetic is unsigned only; signed mult is out of scope. Adder cout is always captured into hi_reg[31], so there is no overflow loss.
- counter never wraps: it is cleared on accept and stops at N_ITER-1.

Decomposition:
- Shared package/header (mips_defs): state encodings MS_IDLE = 2'd0, MS_CALC = 2'd1, MS_DONE = 2'd2; constant MULT_ITER = 32.
- Sub-module: exactly one instance of _32bit_add.
- FSM, counter and shift registers stay in mult_seq_ctrl itself; no further hierarchy.

Test Plan:
- Reset then idle: product_hi = 0, product_lo = 0, busy = 0, done = 0.
- start with A = 3, B = 5: busy rises after E0; done high exactly in the cycle after E32; product_hi = 0x00000000, product_lo = 0x0000000F.
- A = 0xFFFFFFFF, B = 0xFFFFFFFF: product_hi = 0xFFFFFFFE, product_lo = 0x00000001 (exercises cout capture).
- A = 0x12345678, B = 0: product = 0, latency still 33 cycles to done. Then A = 0x80000000, B = 2: product_hi = 0x00000001, product_lo = 0.
- Pulse start with A = 7, B = 9 at cycle 10 of an in-flight 6x7 multiply: ignored; result is 42 (0x2A). Then start 7x9 back-to-back at the first IDLE cycle: result 63 (0x3F).
- Assert reset at CALC cycle 15: next cycle busy = 0, no done pulse, product = 0. A new start 2x2 completes with product_lo = 4.
